// File: rtl/seg_pkg.sv
// Shared types, constants and the hex font for the seven-segment scan driver.
// Segment encoding is active-low, bit order {a,b,c,d,e,f,g}.
package seg_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Widest anode bus supported; the driver slices the low AN_WIDTH bits.
  localparam int                AN_MAX = 32;
  localparam logic [AN_MAX-1:0] AN_OFF = '1;

  function automatic logic [6:0] hex_to_seg(input nibble_t n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex-to-segment lookup for the currently scanned digit.
module seg_hex_decode
  import seg_pkg::*;
(
  input  nibble_t    nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode hex display driver with frame-synchronised loading,
// leading-zero suppression, PWM dimming and a ghost guard cycle. Optional blink via SEG_BLINK_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int AN_WIDTH     = 8,
  parameter int REFRESH_BITS = 16,
`ifdef SEG_BLINK_EN
  parameter int BLINK_FRAMES = 32,
`endif
  parameter int DUTY_BITS    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  input  logic [NUM_DIGITS-1:0]   load_blank,
  input  logic                    lz_en,
  input  logic [DUTY_BITS-1:0]    brightness,
`ifdef SEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [AN_WIDTH-1:0]     an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [REFRESH_BITS-1:0] prescaler;
  logic [IDX_W-1:0]        idx;
  logic                    tick;
  logic                    boundary;

  assign tick     = en && (&prescaler);
  assign boundary = tick && (idx == LAST_IDX);

  // Explicit wrap keeps idx inside 0..NUM_DIGITS-1 for non-power-of-two digit counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler   <= '0;
      idx         <= '0;
      frame_start <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      frame_start <= boundary;
      if (en) prescaler <= prescaler + 1'b1;
      if (tick) idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
  end

  logic                            pend_full;
  logic                            accept;
  nibble_t [NUM_DIGITS-1:0]        pend_data;
  logic    [NUM_DIGITS-1:0]        pend_dp;
  logic    [NUM_DIGITS-1:0]        pend_blank;
  nibble_t [NUM_DIGITS-1:0]        sh_data;
  logic    [NUM_DIGITS-1:0]        sh_dp;
  logic    [NUM_DIGITS-1:0]        sh_blank;

  assign load_ready = !pend_full;
  assign accept     = load_valid && !pend_full;

  // NOTE: the pending payload has no reset; it is only ever read while pend_full is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      pend_data  <= load_data;
      pend_dp    <= load_dp;
      pend_blank <= load_blank;
    end
  end

  // Accept and transfer are exclusive: a load landing on a boundary waits a full frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_full <= 1'b0;
      sh_data   <= '0;
      sh_dp     <= '0;
      sh_blank  <= '1;
    end else if (accept) begin
      pend_full <= 1'b1;
    end else if (boundary && pend_full) begin
      pend_full <= 1'b0;
      sh_data   <= pend_data;
      sh_dp     <= pend_dp;
      sh_blank  <= pend_blank;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BF_W = $clog2(BLINK_FRAMES) + 1;

  logic [BF_W-1:0] frame_cnt;
  logic            blink_phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (boundary) begin
      if (frame_cnt == BF_W'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= !blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
`endif

  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  upper_zero;

  // A digit is suppressed when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    // NOTE: defaults first so no path through this block leaves a latch.
    lz_blank   = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      // NOTE: blocking = here; upper_zero is a running AND down the digits.
      upper_zero = upper_zero && (sh_data[k] == 4'h0);
      if (k != 0) lz_blank[k] = lz_en && upper_zero;
    end
  end

  nibble_t    cur_nibble;
  logic [6:0] cur_seg;
  logic       visible;

  assign cur_nibble = sh_data[idx];

  seg_hex_decode u_hex_decode (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  // Prescaler 0 is the ghost guard; the top DUTY_BITS of the prescaler set the PWM window.
  always_comb begin
    visible = en
           && !sh_blank[idx]
           && !lz_blank[idx]
           && (prescaler != '0)
           && (prescaler[REFRESH_BITS-1 -: DUTY_BITS] <= brightness);
`ifdef SEG_BLINK_EN
    if (!blink_phase && blink_mask[idx]) visible = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= AN_OFF[AN_WIDTH-1:0];
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else if (visible) begin
      an  <= ~(AN_WIDTH'(1) << idx);
      seg <= cur_seg;
      dp  <= !sh_dp[idx];
    end else begin
      an  <= AN_OFF[AN_WIDTH-1:0];
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: stimulus queues the expected per-slot picture of each
// frame, a monitor collects every 96-cycle frame between frame_start pulses and compares.
module tb_seg_scan_driver;

  localparam int ND = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          load_valid;
  logic          load_ready;
  logic [23:0]   load_data;
  logic [ND-1:0] load_dp;
  logic [ND-1:0] load_blank;
  logic          lz_en;
  logic [1:0]    brightness;
  logic [7:0]    an;
  logic [6:0]    seg;
  logic          dp;
  logic          frame_start;
`ifdef SEG_BLINK_EN
  logic [ND-1:0] blink_mask = '0;
`endif

  always #5 clk = ~clk;

  seg_scan_driver #(
    .NUM_DIGITS   (ND),
    .AN_WIDTH     (8),
    .REFRESH_BITS (4),
    .DUTY_BITS    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .load_dp     (load_dp),
    .load_blank  (load_blank),
    .lz_en       (lz_en),
    .brightness  (brightness),
`ifdef SEG_BLINK_EN
    .blink_mask  (blink_mask),
`endif
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  typedef struct packed {
    logic [ND-1:0][4:0] lit;
    logic [ND-1:0][6:0] seg;
    logic [ND-1:0]      dp;
  } frame_t;

  frame_t exp_q[$];
  int     total = 0;
  int     bad   = 0;
  bit     mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // segs = {slot5 .. slot0}; 7F marks a dark slot. dpl = decimal points lit (1 = on).
  function automatic frame_t mkf(input logic [41:0] segs, input logic [5:0] dpl, input int lvl);
    frame_t f;
    for (int k = 0; k < ND; k++) begin
      f.seg[k] = segs[7*k +: 7];
      if (f.seg[k] == 7'h7F) begin
        f.lit[k] = 5'd0;
        f.dp[k]  = 1'b1;
      end else begin
        f.lit[k] = 5'(lvl);
        f.dp[k]  = ~dpl[k];
      end
    end
    return f;
  endfunction

  // Monitor: a frame is the 96 negedge samples after a frame_start sample.
  initial begin : monitor
    bit         synced;
    bit         aborted;
    int         lit [ND];
    logic [6:0] sg  [ND];
    logic       dpo [ND];
    int         glitch;
    int         fs_extra;
    int         s;
    int         ph;
    logic       last_fs;
    frame_t     e;
    synced = 1'b0;
    forever begin
      if (!synced) begin
        @(negedge clk);
        synced = mon_en && !rst && frame_start;
      end else begin
        aborted  = 1'b0;
        glitch   = 0;
        fs_extra = 0;
        last_fs  = 1'b0;
        for (int k = 0; k < ND; k++) begin
          lit[k] = 0;
          sg[k]  = 7'h7F;
          dpo[k] = 1'b1;
        end
        for (int c = 0; c < 96; c++) begin
          @(negedge clk);
          if (rst || !mon_en) begin
            aborted = 1'b1;
            break;
          end
          s  = c / 16;
          ph = c % 16;
          if (c == 95) last_fs = frame_start;
          else if (frame_start) fs_extra++;
          if (an === 8'hFF) begin
            if (seg !== 7'h7F || dp !== 1'b1) glitch++;
          end else begin
            if (ph == 0 || an !== ~(8'h01 << s)) glitch++;
            if (lit[s] == 0) begin
              sg[s]  = seg;
              dpo[s] = dp;
            end else if (seg !== sg[s] || dp !== dpo[s]) begin
              glitch++;
            end
            lit[s]++;
          end
        end
        if (aborted) begin
          synced = 1'b0;
        end else begin
          check("frame_start after 96 cycles", 32'(last_fs), 32'd1);
          check("frame_start spurious pulses", fs_extra, 0);
          check("anode/segment glitches", glitch, 0);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int k = 0; k < ND; k++) begin
              check($sformatf("slot%0d lit cycles", k), lit[k], 32'(e.lit[k]));
              check($sformatf("slot%0d seg", k), 32'(sg[k]), 32'(e.seg[k]));
              check($sformatf("slot%0d dp", k), 32'(dpo[k]), 32'(e.dp[k]));
            end
          end
          synced = last_fs;
        end
      end
    end
  end

  // Returns #1 after the negedge that shows frame_start; lit_seen counts lit samples on the way.
  task automatic wait_frame(output int lit_seen);
    int n = 0;
    lit_seen = 0;
    do begin
      @(negedge clk);
      n++;
      if (an !== 8'hFF) lit_seen++;
    end while (!frame_start && n < 300);
    check("frame_start within bound", 32'(frame_start), 32'd1);
    #1;
  endtask

  task automatic do_load(input logic [23:0] d, input logic [5:0] p, input logic [5:0] b);
    int n = 0;
    while (!load_ready && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("load_ready before load", 32'(load_ready), 32'd1);
    load_data  = d;
    load_dp    = p;
    load_blank = b;
    load_valid = 1'b1;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  initial begin : stimulus
    frame_t f_num, f_a, f_b, f_45, f_45lz, f_45dim, f_45dp, f_zero, f_blank;
    int     n;
    int     fs_cnt;
    int     lit_cnt;

    f_num   = mkf({7'h4F, 7'h12, 7'h06, 7'h4C, 7'h08, 7'h60}, 6'b0, 15);
    f_a     = mkf({7'h24, 7'h20, 7'h0F, 7'h00, 7'h04, 7'h01}, 6'b0, 15);
    f_b     = mkf({7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08}, 6'b0, 15);
    f_45    = mkf({7'h01, 7'h01, 7'h01, 7'h01, 7'h4C, 7'h24}, 6'b0, 15);
    f_45lz  = mkf({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h4C, 7'h24}, 6'b0, 15);
    f_45dim = mkf({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h4C, 7'h24}, 6'b0, 3);
    f_45dp  = mkf({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h4C, 7'h24}, 6'b000010, 15);
    f_zero  = mkf({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h01}, 6'b0, 15);
    f_blank = mkf({7'h7F, 7'h12, 7'h06, 7'h7F, 7'h08, 7'h60}, 6'b0, 15);

    rst        = 1'b1;
    en         = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_dp    = '0;
    load_blank = '0;
    lz_en      = 1'b0;
    brightness = 2'd3;
    repeat (3) @(posedge clk);
    #1;
    check("reset an", 32'(an), 32'hFF);
    check("reset seg", 32'(seg), 32'h7F);
    check("reset dp", 32'(dp), 32'd1);
    check("reset frame_start", 32'(frame_start), 32'd0);
    check("reset load_ready", 32'(load_ready), 32'd1);

    @(negedge clk);
    rst    = 1'b0;
    en     = 1'b1;
    mon_en = 1'b1;

    // Basic scan and free run.
    do_load(24'h1234AB, 6'b0, 6'b0);
    check("ready low after load", 32'(load_ready), 32'd0);
    wait_frame(n);
    check("dark before first boundary", n, 0);
    exp_q.push_back(f_num);
    repeat (21) begin
      wait_frame(n);
      exp_q.push_back(f_num);
    end

    // Second offer while pending is full waits for the boundary.
    wait_frame(n);
    exp_q.push_back(f_num);
    repeat (10) @(posedge clk);
    #1;
    do_load(24'h567890, 6'b0, 6'b0);
    load_data  = 24'hFEDCBA;
    load_valid = 1'b1;
    @(posedge clk);
    #1;
    check("ready low while pending", 32'(load_ready), 32'd0);
    repeat (30) @(posedge clk);
    #1;
    check("ready still low mid-frame", 32'(load_ready), 32'd0);
    wait_frame(n);
    exp_q.push_back(f_a);
    check("ready back after boundary", 32'(load_ready), 32'd1);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    check("second load accepted", 32'(load_ready), 32'd0);
    wait_frame(n);
    exp_q.push_back(f_b);

    // Load accepted exactly on the boundary cycle stays pending for a whole frame.
    repeat (95) @(posedge clk);
    #1;
    load_data  = 24'h000045;
    load_dp    = 6'b0;
    load_blank = 6'b0;
    load_valid = 1'b1;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    check("boundary load pending", 32'(load_ready), 32'd0);
    wait_frame(n);
    exp_q.push_back(f_b);
    check("boundary load still pending", 32'(load_ready), 32'd0);
    wait_frame(n);
    exp_q.push_back(f_45);
    check("ready after next boundary", 32'(load_ready), 32'd1);

    // Leading-zero suppression, dimming, decimal point, all-zero, blanking.
    wait_frame(n);
    lz_en = 1'b1;
    exp_q.push_back(f_45lz);
    wait_frame(n);
    brightness = 2'd0;
    exp_q.push_back(f_45dim);
    wait_frame(n);
    brightness = 2'd3;
    exp_q.push_back(f_45lz);
    do_load(24'h000045, 6'b000010, 6'b0);
    wait_frame(n);
    exp_q.push_back(f_45dp);
    do_load(24'h000000, 6'b0, 6'b0);
    wait_frame(n);
    exp_q.push_back(f_zero);
    do_load(24'h1234AB, 6'b0, 6'b100100);
    wait_frame(n);
    exp_q.push_back(f_blank);
    wait_frame(n);
    mon_en = 1'b0;
    check("scoreboard drained", exp_q.size(), 0);

    // Scan enable: dark while low, resumes on the same slot.
    repeat (5) @(posedge clk);
    #1;
    check("slot0 lit before en low", 32'(an), 32'hFE);
    en = 1'b0;
    @(posedge clk);
    #1;
    check("dark after en low", 32'(an), 32'hFF);
    fs_cnt  = 0;
    lit_cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (frame_start) fs_cnt++;
      if (an !== 8'hFF) lit_cnt++;
    end
    check("no frame_start while held", fs_cnt, 0);
    check("dark while held", lit_cnt, 0);
    en = 1'b1;
    @(posedge clk);
    #1;
    check("resumes on slot0", 32'(an), 32'hFE);

    // Asynchronous reset mid-slot.
    do_load(24'h567890, 6'b0, 6'b0);
    check("pending full before reset", 32'(load_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("lit before reset", 32'(an), 32'hFE);
    #1;
    rst = 1'b1;
    #1;
    check("async reset an", 32'(an), 32'hFF);
    check("async reset seg", 32'(seg), 32'h7F);
    check("async reset dp", 32'(dp), 32'd1);
    check("async reset load_ready", 32'(load_ready), 32'd1);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    wait_frame(n);
    check("dark after reset", n, 0);
    do_load(24'h1234AB, 6'b0, 6'b0);
    wait_frame(n);
    check("dark until load passes boundary", n, 0);
    exp_q.push_back(f_num);
    wait_frame(n);
    check("final scoreboard drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
